// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the gate truth-table sequencer.
package gate_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_DONE = 2'd2
   } seq_state_e;

   localparam int NUM_COMBOS = 4;
   localparam int GATES      = 7;

   // Row idx holds {xnor,xor,nor,nand,not,or,and} for a=idx[0], b=idx[1].
   localparam logic [NUM_COMBOS*GATES-1:0] GOLDEN_TABLE = 28'h86B955C;

   function automatic logic [GATES-1:0] golden_row(input logic [1:0] idx);
      return GOLDEN_TABLE[int'(idx)*GATES +: GATES];
   endfunction

endpackage

// File: rtl/basic_gates.sv
// Two-input gate datapath: and, or, not(a), nand, nor, xor, xnor.
module basic_gates (
   input  logic a,
   input  logic b,
   output logic x_and,
   output logic x_or,
   output logic x_not,
   output logic x_nand,
   output logic x_nor,
   output logic x_xor,
   output logic x_xnor
);

   assign x_and  = a & b;
   assign x_or   = a | b;
   assign x_not  = ~a;
   assign x_nand = ~(a & b);
   assign x_nor  = ~(a | b);
   assign x_xor  = a ^ b;
   assign x_xnor = ~(a ^ b);

endmodule

// File: rtl/step_timer.sv
// Hold counter: counts 0..STEP_CYCLES-1 while enabled, tc flags the last count.
module step_timer #(
   parameter int STEP_CYCLES = 50000000,
   parameter int CNT_W       = $clog2(STEP_CYCLES)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

   logic [CNT_W-1:0] count;

   assign tc = (count == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= tc ? '0 : count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/gate_truth_sequencer.sv
// Steps the gate inputs through all four (a,b) combinations and captures a truth table.
// Optional GATE_SELF_CHECK_EN adds a sticky err output comparing captures to the golden table.
module gate_truth_sequencer
   import gate_seq_pkg::*;
#(
   parameter int  STEP_CYCLES = 50000000,
   localparam int CNT_W       = $clog2(STEP_CYCLES)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        pause,
   output logic        a_o,
   output logic        b_o,
   output logic [6:0]  led,
   output logic [27:0] table_o,
   output logic        busy,
   output logic        done
`ifdef GATE_SELF_CHECK_EN
   ,output logic       err
`endif
);

   seq_state_e state, state_nxt;
   logic [1:0] idx;
   logic       accept;
   logic       capture;
   logic       timer_en;
   logic       timer_tc;
   logic       x_and, x_or, x_not, x_nand, x_nor, x_xor, x_xnor;

   basic_gates u_gates (
      .a      (a_o),
      .b      (b_o),
      .x_and  (x_and),
      .x_or   (x_or),
      .x_not  (x_not),
      .x_nand (x_nand),
      .x_nor  (x_nor),
      .x_xor  (x_xor),
      .x_xnor (x_xnor)
   );

   assign led = {x_xnor, x_xor, x_nor, x_nand, x_not, x_or, x_and};

   assign timer_en = (state == ST_HOLD) && !pause;

   step_timer #(
      .STEP_CYCLES (STEP_CYCLES),
      .CNT_W       (CNT_W)
   ) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (accept),
      .en    (timer_en),
      .tc    (timer_tc)
   );

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      capture   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (timer_en && timer_tc) begin
               capture = 1'b1;
               if (idx == 2'd3) state_nxt = ST_DONE;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // idx wraps 3 -> 0 on the last capture, returning a_o/b_o to 00 for DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx     <= 2'd0;
         table_o <= '0;
      end else if (accept) begin
         idx     <= 2'd0;
         table_o <= '0;
      end else if (capture) begin
         idx                             <= idx + 2'd1;
         table_o[int'(idx)*GATES +: GATES] <= led;
      end
   end

   assign a_o  = idx[0];
   assign b_o  = idx[1];
   assign busy = (state == ST_HOLD);
   assign done = (state == ST_DONE);

`ifdef GATE_SELF_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if (accept) begin
         err <= 1'b0;
      end else if (capture && (led != golden_row(idx))) begin
         err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Directed bench for gate_truth_sequencer with STEP_CYCLES=4.
module tb_gate_truth_sequencer;

   localparam int STEP = 4;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        pause;
   logic        a_o;
   logic        b_o;
   logic [6:0]  led;
   logic [27:0] table_o;
   logic        busy;
   logic        done;
`ifdef GATE_SELF_CHECK_EN
   logic        err;
`endif

   int checks = 0;
   int errors = 0;

   logic [6:0]  led_exp [4];
   logic [27:0] table_exp;

   gate_truth_sequencer #(.STEP_CYCLES(STEP)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .pause   (pause),
      .a_o     (a_o),
      .b_o     (b_o),
      .led     (led),
      .table_o (table_o),
      .busy    (busy),
      .done    (done)
`ifdef GATE_SELF_CHECK_EN
      ,.err    (err)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check_eq({tag, "_a"},     32'(a_o),     32'd0);
      check_eq({tag, "_b"},     32'(b_o),     32'd0);
      check_eq({tag, "_led"},   32'(led),     32'h5C);
      check_eq({tag, "_table"}, 32'(table_o), 32'd0);
      check_eq({tag, "_busy"},  32'(busy),    32'd0);
      check_eq({tag, "_done"},  32'(done),    32'd0);
   endtask

   // One full run; pause is high for cycles p_start..p_start+p_len-1 of the run.
   // Returns at the negedge of the first IDLE cycle after DONE.
   task automatic run_check(input int p_start, input int p_len, input bit hold_start);
      int up;
      int exp_idx;
      logic [1:0] ei;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = hold_start;
      up = 0;
      for (int c = 1; c <= 4*STEP + p_len; c++) begin
         if (c > 1) @(negedge clk);
         pause   = (p_len > 0) && (c >= p_start) && (c < p_start + p_len);
         exp_idx = up / STEP;
         ei      = exp_idx[1:0];
         check_eq("run_busy", 32'(busy), 32'd1);
         check_eq("run_done", 32'(done), 32'd0);
         check_eq("run_a",    32'(a_o),  32'(ei[0]));
         check_eq("run_b",    32'(b_o),  32'(ei[1]));
         check_eq("run_led",  32'(led),  32'(led_exp[exp_idx]));
         if (!pause) up++;
      end
      @(negedge clk);
      pause = 1'b0;
      check_eq("done_pulse", 32'(done),    32'd1);
      check_eq("done_busy",  32'(busy),    32'd0);
      check_eq("done_table", 32'(table_o), 32'(table_exp));
      check_eq("done_ab",    32'({b_o, a_o}), 32'd0);
      @(negedge clk);
      check_eq("idle_done",  32'(done),    32'd0);
      check_eq("idle_busy",  32'(busy),    32'd0);
      check_eq("idle_table", 32'(table_o), 32'(table_exp));
   endtask

   initial begin
      led_exp[0] = 7'h5C;
      led_exp[1] = 7'h2A;
      led_exp[2] = 7'h2E;
      led_exp[3] = 7'h43;
      table_exp  = 28'h86B955C;
      rst_n = 1'b0;
      start = 1'b0;
      pause = 1'b0;

      // reset state
      repeat (2) @(negedge clk);
      check_reset_values("reset");
`ifdef GATE_SELF_CHECK_EN
      check_eq("reset_err", 32'(err), 32'd0);
`endif
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("idle_no_start_busy", 32'(busy), 32'd0);

      // normal run
      run_check(0, 0, 1'b0);

      // pause for 3 cycles during idx=1
      run_check(6, 3, 1'b0);

      // start held high: ignored while busy and in DONE, restarts from next IDLE
      run_check(0, 0, 1'b1);
      @(negedge clk);
      start = 1'b0;
      check_eq("restart_busy",  32'(busy),    32'd1);
      check_eq("restart_table", 32'(table_o), 32'd0);
      check_eq("restart_ab",    32'({b_o, a_o}), 32'd0);

      // reset mid-run at idx=2
      repeat (2*STEP) @(negedge clk);
      check_eq("pre_reset_a", 32'(a_o), 32'd0);
      check_eq("pre_reset_b", 32'(b_o), 32'd1);
      check_eq("pre_reset_table_lo", 32'(table_o[13:0]), 32'(table_exp[13:0]));
      #1 rst_n = 1'b0;
      #1 check_reset_values("async_reset");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("reset_no_done", 32'(done), 32'd0);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 2*STEP; i++) begin
         @(negedge clk);
         check_eq("post_reset_idle_done", 32'(done), 32'd0);
         check_eq("post_reset_idle_busy", 32'(busy), 32'd0);
      end

`ifdef GATE_SELF_CHECK_EN
      // forced and-gate at idx=3 must set err
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3*STEP) @(negedge clk);
      check_eq("err_pre_idx3", 32'({b_o, a_o}), 32'd3);
      check_eq("err_before",   32'(err), 32'd0);
      force dut.x_and = 1'b0;
      repeat (STEP - 1) @(negedge clk);
      check_eq("err_before_capture", 32'(err), 32'd0);
      @(negedge clk);
      check_eq("err_done",    32'(done), 32'd1);
      check_eq("err_set",     32'(err),  32'd1);
      check_eq("err_row3",    32'(table_o[27:21]), 32'h42);
      release dut.x_and;
      @(negedge clk);
      check_eq("err_sticky",  32'(err), 32'd1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_eq("err_cleared", 32'(err),  32'd0);
      check_eq("err_busy",    32'(busy), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
